// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// decode_pkg : MIPS decode constants, field layout and legality lookups
// Rev 1.0    : initial release
// ============================================================================
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;

  typedef struct packed {
    logic [1:0] fmt;
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } dec_fields_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: op_is_legal = 1'b1;
      default:                                                  op_is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic funct_is_legal(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: funct_is_legal = 1'b1;
      default:                                        funct_is_legal = 1'b0;
    endcase
  endfunction

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic op_zero_ext(input logic [5:0] op);
    op_zero_ext = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_pipe_fields.sv
`default_nettype none
// ============================================================================
// decode_fields : combinational split of one instruction into its decoded bundle
// Rev 1.0       : initial release (out_illegal under DECODE_STAGE_ILLEGAL_EN)
// ============================================================================
module decode_fields
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output dec_fields_t     fields,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] jump_addr
`ifdef DECODE_STAGE_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  logic [XLEN-1:0] pc_plus4;
  logic            sign_bit;
  logic            unused_pc_low;

  always_comb begin
    fields.opcode = instr[OPCODE_LSB +: 6];
    fields.rs     = instr[RS_LSB +: 5];
    fields.rt     = instr[RT_LSB +: 5];
    fields.rd     = instr[RD_LSB +: 5];
    fields.shamt  = instr[SHAMT_LSB +: 5];
    fields.funct  = instr[FUNCT_LSB +: 6];

    if (fields.opcode == OP_RTYPE)
      fields.fmt = FMT_R;
    else if ((fields.opcode == OP_J) || (fields.opcode == OP_JAL))
      fields.fmt = FMT_J;
    else
      fields.fmt = FMT_I;

    sign_bit = ~op_zero_ext(fields.opcode) & instr[15];
    imm_ext  = {{(XLEN-16){sign_bit}}, instr[15:0]};

    // Wraps naturally modulo 2^XLEN.
    pc_plus4  = pc + XLEN'(4);
    jump_addr = {pc_plus4[XLEN-1:28], instr[25:0], 2'b00};
  end

  // Only the region bits of pc+4 reach the jump target.
  assign unused_pc_low = ^pc_plus4[27:0];

`ifdef DECODE_STAGE_ILLEGAL_EN
  assign illegal = ~op_is_legal(fields.opcode) |
                   ((fields.opcode == OP_RTYPE) & ~funct_is_legal(fields.funct));
`endif

endmodule
`default_nettype wire

// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// decode_stage_pipe : pipelined MIPS decode with a DEPTH-entry elastic buffer
// Options           : DECODE_STAGE_ILLEGAL_EN adds out_illegal
// Rev 1.0           : initial release
// ============================================================================
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_fmt,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_funct,
  output logic [XLEN-1:0] out_imm_ext,
  output logic [XLEN-1:0] out_jump_addr,
  output logic [XLEN-1:0] out_pc
`ifdef DECODE_STAGE_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);

  localparam logic [1:0] C_DEPTH = DEPTH[1:0];

  typedef struct packed {
    dec_fields_t     f;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] jump_addr;
    logic [XLEN-1:0] pc;
`ifdef DECODE_STAGE_ILLEGAL_EN
    logic            illegal;
`endif
  } entry_t;

  entry_t     new_entry;
  entry_t     slot_q [DEPTH];
  entry_t     slot_d [DEPTH];
  logic [1:0] count_q, count_d;
  logic [1:0] wr_idx;
  logic       push, pop;

  decode_fields #(.XLEN(XLEN)) u_fields (
    .instr     (in_instr),
    .pc        (in_pc),
    .fields    (new_entry.f),
    .imm_ext   (new_entry.imm_ext),
    .jump_addr (new_entry.jump_addr)
`ifdef DECODE_STAGE_ILLEGAL_EN
    ,
    .illegal   (new_entry.illegal)
`endif
  );
  assign new_entry.pc = in_pc;

  // A single-entry buffer can refill in the same cycle its head drains.
  generate
    if (DEPTH == 1) begin : g_ready_one
      assign in_ready = ~rst & ((count_q == 2'd0) | out_ready);
    end else begin : g_ready_two
      assign in_ready = ~rst & (count_q < C_DEPTH);
    end
  endgenerate

  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign wr_idx    = count_q - {1'b0, pop};

  // Slot 0 is always the head; it is only overwritten when real data replaces it,
  // so the outputs hold their last values once the buffer drains.
  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop && (count_q == 2'd2))
        slot_d[0] = slot_q[DEPTH-1];
      for (int i = 0; i < DEPTH; i++)
        if (push && (wr_idx == i[1:0]))
          slot_d[i] = new_entry;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      for (int i = 0; i < DEPTH; i++)
        slot_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++)
        slot_q[i] <= slot_d[i];
    end
  end

  assign out_fmt       = slot_q[0].f.fmt;
  assign out_opcode    = slot_q[0].f.opcode;
  assign out_rs        = slot_q[0].f.rs;
  assign out_rt        = slot_q[0].f.rt;
  assign out_rd        = slot_q[0].f.rd;
  assign out_shamt     = slot_q[0].f.shamt;
  assign out_funct     = slot_q[0].f.funct;
  assign out_imm_ext   = slot_q[0].imm_ext;
  assign out_jump_addr = slot_q[0].jump_addr;
  assign out_pc        = slot_q[0].pc;
`ifdef DECODE_STAGE_ILLEGAL_EN
  assign out_illegal   = slot_q[0].illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// tb_decode_stage_pipe : directed and queue-checked bench for decode_stage_pipe
// Rev 1.0              : initial release
// ============================================================================
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_fmt;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [5:0]  out_funct;
  logic [31:0] out_imm_ext, out_jump_addr, out_pc;
`ifdef DECODE_STAGE_ILLEGAL_EN
  logic        out_illegal;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage_pipe #(.XLEN(32), .DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_fmt       (out_fmt),
    .out_opcode    (out_opcode),
    .out_rs        (out_rs),
    .out_rt        (out_rt),
    .out_rd        (out_rd),
    .out_shamt     (out_shamt),
    .out_funct     (out_funct),
    .out_imm_ext   (out_imm_ext),
    .out_jump_addr (out_jump_addr),
    .out_pc        (out_pc)
`ifdef DECODE_STAGE_ILLEGAL_EN
    ,
    .out_illegal   (out_illegal)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    #1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if ({out_fmt, out_opcode, out_funct, out_imm_ext, out_jump_addr, out_pc} !== '0) begin
      errors++; $display("FAIL reset_outputs: pc=%h imm=%h not all zero", out_pc, out_imm_ext);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_rtype();
    push(32'h00221820, 32'h0000_0100);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rtype_valid: got %b want 1", out_valid); end
    checks++;
    if ({out_fmt, out_rs, out_rt, out_rd, out_shamt, out_funct} !== {2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}) begin
      errors++;
      $display("FAIL rtype_fields: fmt=%0d rs=%0d rt=%0d rd=%0d sh=%0d fn=%h want 0/1/2/3/0/20",
               out_fmt, out_rs, out_rt, out_rd, out_shamt, out_funct);
    end
    checks++;
    if (out_pc !== 32'h100) begin errors++; $display("FAIL rtype_pc: got %h want 00000100", out_pc); end
    pop();
    checks++;
    if (out_valid !== 1'b0 || out_funct !== 6'h20) begin
      errors++; $display("FAIL rtype_hold: valid=%b funct=%h want 0/20", out_valid, out_funct);
    end
  endtask

  task automatic test_imm();
    logic [31:0] ins [5] = '{32'h2021FFFF, 32'h3021FFFF, 32'h8C410004, 32'h3C018000, 32'h28218000};
    logic [31:0] imm [5] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h00000004, 32'h00008000, 32'hFFFF8000};
    for (int i = 0; i < 5; i++) begin
      push(ins[i], 32'h200 + 32'(i * 4));
      checks++;
      if (out_imm_ext !== imm[i] || out_fmt !== 2'd1) begin
        errors++;
        $display("FAIL imm_%0d: imm=%h fmt=%0d want %h/1", i, out_imm_ext, out_fmt, imm[i]);
      end
      pop();
    end
    push(32'h8C410004, 32'h300);
    checks++;
    if (out_opcode !== 6'h23 || out_rs !== 5'd2 || out_rt !== 5'd1) begin
      errors++; $display("FAIL lw_fields: op=%h rs=%0d rt=%0d want 23/2/1", out_opcode, out_rs, out_rt);
    end
    pop();
  endtask

  task automatic test_jump();
    logic [31:0] ins [3] = '{32'h08000010, 32'h08000010, 32'h0C000001};
    logic [31:0] pcs [3] = '{32'h40000000, 32'hFFFFFFFC, 32'h80000000};
    logic [31:0] jad [3] = '{32'h40000040, 32'h00000040, 32'h80000004};
    for (int i = 0; i < 3; i++) begin
      push(ins[i], pcs[i]);
      checks++;
      if (out_jump_addr !== jad[i] || out_fmt !== 2'd2) begin
        errors++;
        $display("FAIL jump_%0d: addr=%h fmt=%0d want %h/2", i, out_jump_addr, out_fmt, jad[i]);
      end
      pop();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc [3] = '{32'hA00, 32'hA04, 32'hA08};
    out_ready = 1'b0;
    push(32'h00221820, 32'hA00);
    push(32'h2021FFFF, 32'hA04);
    in_valid = 1'b1; in_instr = 32'h3021FFFF; in_pc = 32'hA08;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    tick();
    checks++;
    if (out_pc !== 32'hA00 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold: pc=%h ready=%b want A00/0", out_pc, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[i]) begin
        errors++; $display("FAIL bp_order_%0d: valid=%b pc=%h want 1/%h", i, out_valid, out_pc, exp_pc[i]);
      end
      tick();
      if (i == 1) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: valid=%b want 0", out_valid); end
  endtask

  task automatic test_random();
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t q [$];
    logic exp_ready, do_push, do_pop;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_instr  = $urandom;
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = (q.size() < 2);
      checks++;
      if (in_ready !== exp_ready || out_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rand_hs_%0d: ready=%b valid=%b want %b/%b", c, in_ready, out_valid, exp_ready, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if (out_pc !== q[0].pc ||
            {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct} !== q[0].instr) begin
          errors++;
          $display("FAIL rand_head_%0d: pc=%h want %h", c, out_pc, q[0].pc);
        end
      end
      do_pop  = (q.size() != 0) && out_ready;
      do_push = in_valid && exp_ready;
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{pc: in_pc, instr: in_instr});
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    push(32'h00221820, 32'h1000);
    in_valid = 1'b1; in_instr = 32'h2021FFFF; in_pc = 32'h1004; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_one: valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    push(32'h00221820, 32'h1100);
    push(32'h3021FFFF, 32'h1104);
    in_valid = 1'b1; in_instr = 32'h8C410004; in_pc = 32'h1108; flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h1100) begin
      errors++; $display("FAIL flush_two: valid=%b pc=%h want 0/1100", out_valid, out_pc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty: valid=%b want 0", out_valid); end
    push(32'h08000010, 32'h110C);
    checks++;
    if (out_pc !== 32'h110C) begin errors++; $display("FAIL flush_next_head: pc=%h want 110C", out_pc); end
    pop();
  endtask

  task automatic test_reset_mid();
    push(32'h00221820, 32'h2000);
    in_valid = 1'b1; in_instr = 32'h2021FFFF; in_pc = 32'h2004; rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || {out_pc, out_imm_ext, out_jump_addr, out_funct, out_rs} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: valid=%b pc=%h imm=%h want all 0", out_valid, out_pc, out_imm_ext);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release: ready=%b want 1", in_ready); end
  endtask

`ifdef DECODE_STAGE_ILLEGAL_EN
  task automatic test_illegal();
    logic [31:0] ins [3] = '{32'hFC000000, 32'h0000003F, 32'h00221820};
    logic        exp [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      push(ins[i], 32'h3000);
      checks++;
      if (out_illegal !== exp[i] || out_valid !== 1'b1) begin
        errors++; $display("FAIL illegal_%0d: ill=%b valid=%b want %b/1", i, out_illegal, out_valid, exp[i]);
      end
      pop();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_imm();
    test_jump();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
`ifdef DECODE_STAGE_ILLEGAL_EN
    test_illegal();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Pipelined MIPS instruction-decode stage and parametrised successor of decoder_32. Splits a 32-bit instruction into opcode/rs/rt/rd/shamt/funct fields, classifies the format (R/I/J), extends the immediate to XLEN and forms the absolute jump address. Decoded results are held in a 2-entry elastic buffer with valid/ready handshakes on both sides. Sits between fetch and register-read/execute.

Parameters:
XLEN, 32, datapath/PC width; immediate extended to XLEN; must be >= 32.
DEPTH, 2, buffer entries; legal values 1 or 2. With 1, in_ready depends on out_ready (pass-through pop).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  discard all buffered entries and the same-cycle input
in_valid  input  1  fetch offers an instruction
in_ready  output  1  stage accepts this cycle
in_instr  input  32  raw instruction word
in_pc  input  XLEN  address of in_instr
out_valid  output  1  head entry valid
out_ready  input  1  consumer takes the head entry
out_fmt  output  2  0=R, 1=I, 2=J, 3 unused
out_opcode  output  6  instr[31:26]
out_rs  output  5  instr[25:21]
out_rt  output  5  instr[20:16]
out_rd  output  5  instr[15:11]
out_shamt  output  5  instr[10:6]
out_funct  output  6  instr[5:0]
out_imm_ext  output  XLEN  extended instr[15:0]
out_jump_addr  output  XLEN  {pc_plus4[XLEN-1:28], instr[25:0], 2'b00}
out_pc  output  XLEN  PC of head entry

Behaviour:
- Reset (rst high at a clock edge): count=0, all out_* = 0, out_valid=0. in_ready is forced to 0 while rst is high. Reset mid-transfer drops every entry, with no partial output.
- Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready.
- in_ready = ~rst & (count < DEPTH). For DEPTH=1: in_ready = ~rst & (count==0 | out_ready).
- Decode is combinational on in_instr and stored at push. Latency is 1: an instruction accepted at edge N gives out_valid=1 at edge N, visible in cycle N+1.
- FIFO order is strict. Simultaneous push and pop at count=1 keeps count at 1 and makes the new entry the head next cycle. At count=DEPTH no push happens.
- out_* show the head entry while out_valid=1 and hold stable until it is popped. When count=0, out_* hold their last values and out_valid=0.
- Flush: count=0 at the next edge and the same-cycle input is discarded. Flush takes priority over push and pop. The consumer must not count a pop in the flush cycle.
- fmt: opcode 0x00 -> R. Opcode 0x02 or 0x03 -> J. All other opcodes -> I. All fields are always emitted regardless of fmt.
- Immediate: zero-extended for opcodes 0x0C/0x0D/0x0E/0x0F (ANDI/ORI/XORI/LUI). All other opcodes are sign-extended from bit 15.
- pc_plus4 = in_pc + 4, modulo 2^XLEN (wraps at the top of the address space).

Optional Feature:
Macro DECODE_STAGE_ILLEGAL_EN.
- Defined: adds output port out_illegal (1 bit), stored per entry. It is 1 when either condition holds:
  - the opcode is not in {0x00,0x02,0x03,0x04,0x05,0x08,0x09,0x0A,0x0B,0x0C,0x0D,0x0E,0x0F,0x23,0x2B};
  - the opcode is 0x00 and funct is not in {0x00,0x02,0x03,0x08,0x20,0x21,0x22,0x23,0x24,0x25,0x26,0x27,0x2A,0x2B}.
  Illegal instructions still flow through normally. out_illegal resets to 0.
- Not defined: the port and its storage are absent; behaviour is otherwise identical.

Decomposition:
- Package decode_pkg holds: opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, ...), the fmt encoding constants FMT_R/FMT_I/FMT_J, field bit positions, and the legal opcode/funct lists.
- One combinational sub-module, decode_fields: instr + pc in, decoded bundle out (fields, fmt, imm_ext, jump_addr, illegal).
- The top level holds the buffer and handshake logic only.

Test Plan:
- R-type: push 0x00221820 -> next cycle out_valid=1, fmt=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20.
- Immediate extension:
  - 0x2021FFFF (ADDI) -> imm_ext=0xFFFFFFFF.
  - 0x3021FFFF (ANDI) -> imm_ext=0x0000FFFF.
  - 0x8C410004 (LW) -> opcode=0x23, rs=2, rt=1, imm_ext=0x00000004, fmt=1.
- Jump: 0x08000010 with pc=0x40000000 -> fmt=2, jump_addr=0x40000040. Same word with pc=0xFFFFFFFC -> pc_plus4 wraps to 0, jump_addr=0x00000040.
- Backpressure: out_ready=0, push 3 instructions back-to-back -> in_ready=0 after 2 pushes and the third is held by fetch. Then out_ready=1 -> entries pop in order with no loss or duplication; a random-stall run matches a reference queue.
- Flush/reset: 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0, count=0, flushed input never appears. Assert rst mid-stream -> out_valid=0 and in_ready=0 during rst, all outputs 0 after.
- With DECODE_STAGE_ILLEGAL_EN defined: opcode 0x3F -> out_illegal=1. 0x0000003F (R-type, funct 0x3F) -> out_illegal=1. 0x00221820 -> out_illegal=0.
